// File: rtl/regfile_dump.sv
// Register-file dump engine: walks registers 0..NUM_REGS-1 through one read-select
// port and streams each word on valid/ready. Optional REGFILE_DUMP_CHKSUM_EN adds Chksum.
module regfile_dump #(
  parameter int NUM_REGS = 8,
  parameter int DATA_W   = 16,
  parameter int SEL_W    = 3
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Start,
  output logic [SEL_W-1:0]  Sel,
  input  logic [DATA_W-1:0] Rd_data,
  output logic [DATA_W-1:0] Dout,
  output logic [SEL_W-1:0]  Dout_idx,
  output logic              Dout_valid,
  input  logic              Dout_ready,
  output logic              Busy,
  output logic              Done,
`ifdef REGFILE_DUMP_CHKSUM_EN
  output logic [DATA_W-1:0] Chksum,
`endif
  output logic [1:0]        Dbg_state
);

  // Handshake: a word transfers at a posedge where Dout_valid & Dout_ready are both
  // high; once raised, Dout_valid and Dout/Dout_idx hold until that transfer.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_REGS - 1);

  state_t            r_state;
  logic [SEL_W-1:0]  r_idx;
  logic [SEL_W-1:0]  r_sel;
  logic [DATA_W-1:0] r_dout;
  logic [SEL_W-1:0]  r_dout_idx;
  logic              r_valid;
  logic              r_busy;
  logic              r_done;
  logic [SEL_W-1:0]  w_idx_next;

  assign w_idx_next = r_idx + 1'b1;

`ifdef REGFILE_DUMP_CHKSUM_EN
  logic [DATA_W-1:0] r_chksum;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_chksum <= '0;
    end else if (r_state == IDLE && Start) begin
      r_chksum <= '0;
    end else if (r_state == SEND && Dout_ready) begin
      r_chksum <= r_chksum + r_dout;
    end
  end

  assign Chksum = r_chksum;
`endif

  // Sel is registered so it already points at r_idx during the whole FETCH cycle.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      r_sel      <= '0;
      r_dout     <= '0;
      r_dout_idx <= '0;
      r_valid    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (Start) begin
            r_state <= FETCH;
            r_idx   <= '0;
            r_sel   <= '0;
            r_busy  <= 1'b1;
          end
        end
        FETCH: begin
          r_dout     <= Rd_data;
          r_dout_idx <= r_idx;
          r_valid    <= 1'b1;
          r_state    <= SEND;
        end
        SEND: begin
          if (Dout_ready) begin
            r_valid <= 1'b0;
            if (r_idx == LAST_IDX) begin
              r_state <= DONE;
              r_done  <= 1'b1;
              r_sel   <= '0;
            end else begin
              r_idx   <= w_idx_next;
              r_sel   <= w_idx_next;
              r_state <= FETCH;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign Sel        = r_sel;
  assign Dout       = r_dout;
  assign Dout_idx   = r_dout_idx;
  assign Dout_valid = r_valid;
  assign Busy       = r_busy;
  assign Done       = r_done;
  assign Dbg_state  = r_state;

endmodule

// File: tb/tb_regfile_dump.sv
// Bench for regfile_dump: directed dumps against a small register array, with a
// scoreboard queue of expected {idx,data} words popped by a separate monitor.
module tb_regfile_dump;

  localparam int DATA_W = 16;
  localparam int SEL_W  = 3;
  localparam int W      = SEL_W + DATA_W;

  logic              Clk;
  logic              Reset_n;
  logic              Start;
  logic [SEL_W-1:0]  Sel;
  logic [DATA_W-1:0] Rd_data;
  logic [DATA_W-1:0] Dout;
  logic [SEL_W-1:0]  Dout_idx;
  logic              Dout_valid;
  logic              Dout_ready;
  logic              Busy;
  logic              Done;
  logic [1:0]        Dbg_state;
`ifdef REGFILE_DUMP_CHKSUM_EN
  logic [DATA_W-1:0] Chksum;
`endif

  logic [DATA_W-1:0] regs [8];
  logic [DATA_W-1:0] exp_vals [8];
  logic [W-1:0]      exp_q [$];
  int                n_cmp;
  int                n_err;
  int                n_words;
  int                n_done;

  assign Rd_data = regs[Sel];

  regfile_dump dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .Start      (Start),
    .Sel        (Sel),
    .Rd_data    (Rd_data),
    .Dout       (Dout),
    .Dout_idx   (Dout_idx),
    .Dout_valid (Dout_valid),
    .Dout_ready (Dout_ready),
    .Busy       (Busy),
    .Done       (Done),
`ifdef REGFILE_DUMP_CHKSUM_EN
    .Chksum     (Chksum),
`endif
    .Dbg_state  (Dbg_state)
  );

  // clock / reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // scoreboard monitor: inputs change just after posedge, so negedge sees the
  // values the next posedge will act on
  always @(negedge Clk) begin
    if (Reset_n && Dout_valid && Dout_ready) begin
      n_cmp++;
      n_words++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL word_unexpected: got idx=%0d data=%h, required none", Dout_idx, Dout);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if ({Dout_idx, Dout} !== e) begin
          n_err++;
          $display("FAIL word: got idx=%0d data=%h, required idx=%0d data=%h",
                   Dout_idx, Dout, e[W-1:DATA_W], e[DATA_W-1:0]);
        end
      end
    end
    if (Reset_n && Done) n_done++;
  end

  // driver tasks
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic push_all();
    for (int i = 0; i < 8; i++) exp_q.push_back({SEL_W'(i), exp_vals[i]});
  endtask

  task automatic set_default_regs();
    for (int i = 0; i < 8; i++) begin
      regs[i]     = DATA_W'(i * 16'h1111);
      exp_vals[i] = DATA_W'(i * 16'h1111);
    end
  endtask

  task automatic pulse_start();
    Start = 1'b1;
    tick();
    Start = 1'b0;
  endtask

  task automatic wait_valid_idx(input int idx);
    int k;
    k = 0;
    while (!(Dout_valid && Dout_idx == SEL_W'(idx)) && k < 60) begin
      tick();
      k++;
    end
    if (k >= 60) begin
      n_cmp++;
      n_err++;
      $display("FAIL timeout_valid_idx%0d: got no valid word, required one within 60 cycles", idx);
    end
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (!Done && k < 60) begin
      tick();
      k++;
    end
    if (k >= 60) begin
      n_cmp++;
      n_err++;
      $display("FAIL timeout_done: got no Done, required one within 60 cycles");
    end
  endtask

  initial begin
    int w0;
    int d0;
    n_cmp      = 0;
    n_err      = 0;
    n_words    = 0;
    n_done     = 0;
    Reset_n    = 1'b0;
    Start      = 1'b0;
    Dout_ready = 1'b1;
    set_default_regs();

    // reset state
    #12;
    check("rst_valid", 32'(Dout_valid), 32'd0);
    check("rst_busy",  32'(Busy),       32'd0);
    check("rst_done",  32'(Done),       32'd0);
    check("rst_dout",  32'(Dout),       32'd0);
    check("rst_idx",   32'(Dout_idx),   32'd0);
    check("rst_sel",   32'(Sel),        32'd0);
    check("rst_state", 32'(Dbg_state),  32'd0);
`ifdef REGFILE_DUMP_CHKSUM_EN
    check("rst_chksum", 32'(Chksum), 32'd0);
`endif
    Reset_n = 1'b1;
    tick();

    // 1: full dump, ready tied high, latency and Done timing
    push_all();
    w0 = n_words;
    d0 = n_done;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    check("t1_busy_t1",  32'(Busy),       32'd1);
    check("t1_valid_t1", 32'(Dout_valid), 32'd0);
    tick();
    check("t1_valid_t2", 32'(Dout_valid), 32'd1);
    check("t1_idx_t2",   32'(Dout_idx),   32'd0);
    for (int t = 3; t <= 17; t++) begin
      tick();
      if (t == 17) check("t1_done_t17", 32'(Done), 32'd1);
      else if (Done) check("t1_done_early", 32'(t), 32'd17);
    end
    tick();
    check("t1_done_width", 32'(Done), 32'd0);
    check("t1_busy_end",   32'(Busy), 32'd0);
    check("t1_words",      32'(n_words - w0), 32'd8);
    check("t1_dones",      32'(n_done - d0),  32'd1);
    check("t1_q_empty",    32'(exp_q.size()), 32'd0);

    // 2: back-pressure on word 3 = BEEF
    regs[3]     = 16'hBEEF;
    exp_vals[3] = 16'hBEEF;
    push_all();
    pulse_start();
    wait_valid_idx(3);
    Dout_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t2_hold_data",  32'(Dout),       32'h0000BEEF);
      check("t2_hold_idx",   32'(Dout_idx),   32'd3);
      check("t2_hold_valid", 32'(Dout_valid), 32'd1);
    end
    Dout_ready = 1'b1;
    wait_done();
    tick();
    check("t2_q_empty", 32'(exp_q.size()), 32'd0);
    set_default_regs();

    // 3: Start pulsed while busy at word 4
    push_all();
    w0 = n_words;
    d0 = n_done;
    pulse_start();
    wait_valid_idx(4);
    pulse_start();
    wait_done();
    tick();
    tick();
    tick();
    check("t3_words",    32'(n_words - w0), 32'd8);
    check("t3_dones",    32'(n_done - d0),  32'd1);
    check("t3_busy_end", 32'(Busy),         32'd0);

    // 4: reset during SEND of word 5, then restart from idx 0
    push_all();
    d0 = n_done;
    pulse_start();
    wait_valid_idx(5);
    Reset_n = 1'b0;
    #1;
    check("t4_valid", 32'(Dout_valid), 32'd0);
    check("t4_busy",  32'(Busy),       32'd0);
    check("t4_done",  32'(Done),       32'd0);
    check("t4_dout",  32'(Dout),       32'd0);
    check("t4_sel",   32'(Sel),        32'd0);
    check("t4_state", 32'(Dbg_state),  32'd0);
    check("t4_q_left", 32'(exp_q.size()), 32'd3);
    exp_q.delete();
    #3;
    Reset_n = 1'b1;
    tick();
    tick();
    check("t4_no_done", 32'(n_done - d0), 32'd0);
    push_all();
    pulse_start();
    tick();
    check("t4_restart_idx", 32'(Dout_idx), 32'd0);
    wait_done();
    tick();
    check("t4_q_empty", 32'(exp_q.size()), 32'd0);

    // 5: regfile writes during word 2 SEND
    exp_vals[6] = 16'hCAFE;
    push_all();
    pulse_start();
    wait_valid_idx(2);
    regs[6] = 16'hCAFE;
    regs[2] = 16'hDEAD;
    wait_done();
    tick();
    check("t5_q_empty", 32'(exp_q.size()), 32'd0);
    set_default_regs();

`ifdef REGFILE_DUMP_CHKSUM_EN
    // 6: checksum, plain sum and wrap
    for (int i = 0; i < 8; i++) begin
      regs[i]     = 16'h0001;
      exp_vals[i] = 16'h0001;
    end
    push_all();
    pulse_start();
    wait_done();
    check("t6_chk_8", 32'(Chksum), 32'h0008);
    tick();
    tick();
    check("t6_chk_hold", 32'(Chksum), 32'h0008);
    for (int i = 0; i < 8; i++) begin
      regs[i]     = 16'h0000;
      exp_vals[i] = 16'h0000;
    end
    regs[0]     = 16'hFFFF;
    exp_vals[0] = 16'hFFFF;
    regs[1]     = 16'h0002;
    exp_vals[1] = 16'h0002;
    push_all();
    pulse_start();
    check("t6_chk_clear", 32'(Chksum), 32'h0000);
    wait_done();
    check("t6_chk_wrap", 32'(Chksum), 32'h0001);
    tick();
`endif

    check("final_q_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
